conv_transpose2d_seq: RTL and testbench

//  Sequential transposed 2-D convolution (deconvolution): the upsampling/backward counterpart of the conv2d layer.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/convt_mac_unit.sv | 68 ++++++
 rtl/conv_transpose2d_seq.sv | 205 ++++++++++++++++++++
 tb/tb_conv_transpose2d_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the transposed 2-D convolution block: FSM state
// encoding and small size/index helpers used by the top and the testbench.
// Optional build macro affecting this block: CONVT_SATURATE_EN.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Output spatial size of a transposed convolution along one axis.
    function automatic int convt_out_dim(input int in_dim, input int k,
                                         input int s, input int p);
        return (in_dim - 1) * s - 2 * p + k;
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Row-major flat index of (a,b,c) in an [*][nb][nc] tensor.
    function automatic int flat_idx3(input int a, input int b, input int c,
                                     input int nb, input int nc);
        return (a * nb + b) * nc + c;
    endfunction

endpackage

// File: rtl/convt_mac_unit.sv
// Single multiply-accumulate lane for conv_transpose2d_seq.
// Load seeds the accumulator with the bias; accumulate adds x*w only when
// the current tap is valid. With CONVT_SATURATE_EN the accumulator is
// double width with full-precision products and the result is clamped;
// otherwise everything wraps at DATA_WIDTH bits.
module convt_mac_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_acc_en,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    output logic signed [DATA_WIDTH-1:0] o_result
);

`ifdef CONVT_SATURATE_EN
    localparam int ACC_W = 2 * DATA_WIDTH;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_bias_ext;

    // Sign-extend operands to the accumulator width before multiplying.
    always_comb begin
        w_bias_ext = ACC_W'(i_bias);
        w_prod     = ACC_W'(i_x) * ACC_W'(i_w);
    end

    // Accumulator: bias load, gated accumulate, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_bias_ext;
        end else if (i_acc_en && i_valid) begin
            r_acc <= r_acc + w_prod;
        end
    end

`ifdef CONVT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp the wide accumulator into the DATA_WIDTH signed range.
    always_comb begin
        if (r_acc > SAT_MAX) begin
            o_result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (r_acc < SAT_MIN) begin
            o_result = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            o_result = r_acc[DATA_WIDTH-1:0];
        end
    end
`else
    // Wrap-around result: accumulator is already DATA_WIDTH wide.
    always_comb begin
        o_result = r_acc;
    end
`endif

endmodule

// File: rtl/conv_transpose2d_seq.sv
// Sequential transposed 2-D convolution, gather formulation, one MAC per
// clock. Each output element takes INIT + N_TAP MAC cycles + WRITE; results
// are published atomically on the done pulse.
// Optional build macro: CONVT_SATURATE_EN (saturating wide accumulation).
module conv_transpose2d_seq
    import conv_pkg::*;
#(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 2,
    parameter int IN_WIDTH     = 2,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]                input_tensor_flat,
    input  logic [IN_CHANNELS*OUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                bias_flat,
    output logic busy,
    output logic done,
    output logic [OUT_CHANNELS*convt_out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING)
                  *convt_out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING)*DATA_WIDTH-1:0] output_tensor_flat
);

    localparam int OUT_HEIGHT = convt_out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
    localparam int OUT_WIDTH  = convt_out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING);
    localparam int N_IN       = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
    localparam int N_W        = IN_CHANNELS * OUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int N_OUT      = OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH;

    localparam int OC_W = cnt_width(OUT_CHANNELS);
    localparam int OH_W = cnt_width(OUT_HEIGHT);
    localparam int OW_W = cnt_width(OUT_WIDTH);
    localparam int IC_W = cnt_width(IN_CHANNELS);
    localparam int K_W  = cnt_width(KERNEL_SIZE);

    state_t r_state;

    logic [N_IN*DATA_WIDTH-1:0]         r_x;
    logic [N_W*DATA_WIDTH-1:0]          r_w;
    logic [OUT_CHANNELS*DATA_WIDTH-1:0] r_b;
    logic [N_OUT*DATA_WIDTH-1:0]        r_result_buf;

    logic [OC_W-1:0] r_oc;
    logic [OH_W-1:0] r_oh;
    logic [OW_W-1:0] r_ow;
    logic [IC_W-1:0] r_ic;
    logic [K_W-1:0]  r_kh;
    logic [K_W-1:0]  r_kw;

    logic signed [31:0] w_th;
    logic signed [31:0] w_tw;
    logic signed [31:0] w_ih;
    logic signed [31:0] w_iw;
    logic signed [31:0] w_x_idx;
    logic signed [31:0] w_w_idx;
    logic signed [31:0] w_out_idx;
    logic               w_tap_valid;
    logic               w_last_tap;
    logic               w_last_elem;

    logic signed [DATA_WIDTH-1:0] w_x_op;
    logic signed [DATA_WIDTH-1:0] w_w_op;
    logic signed [DATA_WIDTH-1:0] w_bias_op;
    logic signed [DATA_WIDTH-1:0] w_acc;

    // Tap-validity decode: which input pixel (if any) feeds this output through this kernel tap.
    always_comb begin
        w_th = $signed(32'(r_oh)) + PADDING - $signed(32'(r_kh));
        w_tw = $signed(32'(r_ow)) + PADDING - $signed(32'(r_kw));
        w_ih = w_th / STRIDE;
        w_iw = w_tw / STRIDE;
        w_tap_valid = (w_th >= 0) && (w_tw >= 0) &&
                      ((w_th % STRIDE) == 0) && ((w_tw % STRIDE) == 0) &&
                      (w_ih < IN_HEIGHT) && (w_iw < IN_WIDTH);
        // Invalid taps point at element 0 so the operand mux never indexes out of range.
        w_x_idx = w_tap_valid ? flat_idx3(32'(r_ic), w_ih, w_iw, IN_HEIGHT, IN_WIDTH) : '0;
        w_w_idx = flat_idx3(32'(r_ic) * OUT_CHANNELS + 32'(r_oc), 32'(r_kh), 32'(r_kw),
                            KERNEL_SIZE, KERNEL_SIZE);
        w_out_idx = flat_idx3(32'(r_oc), 32'(r_oh), 32'(r_ow), OUT_HEIGHT, OUT_WIDTH);
    end

    // Operand muxes and end-of-loop flags.
    always_comb begin
        w_x_op    = r_x[w_x_idx*DATA_WIDTH +: DATA_WIDTH];
        w_w_op    = r_w[w_w_idx*DATA_WIDTH +: DATA_WIDTH];
        w_bias_op = r_b[r_oc*DATA_WIDTH +: DATA_WIDTH];
        w_last_tap  = (r_ic == IC_W'(IN_CHANNELS - 1)) &&
                      (r_kh == K_W'(KERNEL_SIZE - 1)) &&
                      (r_kw == K_W'(KERNEL_SIZE - 1));
        w_last_elem = (r_oc == OC_W'(OUT_CHANNELS - 1)) &&
                      (r_oh == OH_W'(OUT_HEIGHT - 1)) &&
                      (r_ow == OW_W'(OUT_WIDTH - 1));
    end

    convt_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_load   (r_state == INIT),
        .i_acc_en (r_state == MAC),
        .i_valid  (w_tap_valid),
        .i_bias   (w_bias_op),
        .i_x      (w_x_op),
        .i_w      (w_w_op),
        .o_result (w_acc)
    );

    // Control FSM with counters, input capture, result buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            output_tensor_flat <= '0;
            r_result_buf       <= '0;
            r_x                <= '0;
            r_w                <= '0;
            r_b                <= '0;
            r_oc               <= '0;
            r_oh               <= '0;
            r_ow               <= '0;
            r_ic               <= '0;
            r_kh               <= '0;
            r_kw               <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_x     <= input_tensor_flat;
                        r_w     <= weights_flat;
                        r_b     <= bias_flat;
                        r_oc    <= '0;
                        r_oh    <= '0;
                        r_ow    <= '0;
                        r_ic    <= '0;
                        r_kh    <= '0;
                        r_kw    <= '0;
                        busy    <= 1'b1;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_state <= MAC;
                end
                MAC: begin
                    if (w_last_tap) begin
                        r_ic    <= '0;
                        r_kh    <= '0;
                        r_kw    <= '0;
                        r_state <= WRITE;
                    end else if (r_kw != K_W'(KERNEL_SIZE - 1)) begin
                        r_kw <= r_kw + 1'b1;
                    end else begin
                        r_kw <= '0;
                        if (r_kh != K_W'(KERNEL_SIZE - 1)) begin
                            r_kh <= r_kh + 1'b1;
                        end else begin
                            r_kh <= '0;
                            r_ic <= r_ic + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_result_buf[w_out_idx*DATA_WIDTH +: DATA_WIDTH] <= w_acc;
                    if (w_last_elem) begin
                        r_oc    <= '0;
                        r_oh    <= '0;
                        r_ow    <= '0;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_state <= INIT;
                        if (r_ow != OW_W'(OUT_WIDTH - 1)) begin
                            r_ow <= r_ow + 1'b1;
                        end else begin
                            r_ow <= '0;
                            if (r_oh != OH_W'(OUT_HEIGHT - 1)) begin
                                r_oh <= r_oh + 1'b1;
                            end else begin
                                r_oh <= '0;
                                r_oc <= r_oc + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done               <= 1'b1;
                    output_tensor_flat <= r_result_buf;
                    r_state            <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_transpose2d_seq.sv
// Self-checking bench for conv_transpose2d_seq: directed handshake/boundary
// cases plus random data, compared against a scatter-form reference model.
// Expected results follow CONVT_SATURATE_EN when defined.
module tb_conv_transpose2d_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;

    logic [127:0] x1, w1, x2;
    logic [31:0]  b1, b2;
    logic [287:0] w2;
    logic         busy1, done1, busy2, done2;
    logic [511:0] out1;
    logic [127:0] out2;

    always #5 clk = ~clk;

    conv_transpose2d_seq dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .input_tensor_flat(x1), .weights_flat(w1), .bias_flat(b1),
        .busy(busy1), .done(done1), .output_tensor_flat(out1)
    );

    conv_transpose2d_seq #(
        .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .input_tensor_flat(x2), .weights_flat(w2), .bias_flat(b2),
        .busy(busy2), .done(done2), .output_tensor_flat(out2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] xa [4];
    logic [31:0] wa [9];
    logic [31:0] ba;
    logic [31:0] ya [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scatter-form reference: each input pixel spreads x*w over its kernel footprint.
    function automatic void model(input int k, input int s, input int p);
        int oh_n;
        longint acc [16];
        oh_n = (2 - 1) * s - 2 * p + k;
        for (int i = 0; i < 16; i++) acc[i] = longint'($signed(ba));
        for (int ih = 0; ih < 2; ih++)
            for (int iw = 0; iw < 2; iw++)
                for (int kh = 0; kh < k; kh++)
                    for (int kw = 0; kw < k; kw++) begin
                        int oh, ow;
                        oh = ih * s + kh - p;
                        ow = iw * s + kw - p;
                        if (oh >= 0 && oh < oh_n && ow >= 0 && ow < oh_n)
                            acc[oh * oh_n + ow] += longint'($signed(xa[ih * 2 + iw])) *
                                                   longint'($signed(wa[kh * k + kw]));
                    end
        for (int i = 0; i < 16; i++) begin
`ifdef CONVT_SATURATE_EN
            if (acc[i] > 64'sh7FFF_FFFF) ya[i] = 32'h7FFF_FFFF;
            else if (acc[i] < -64'sh8000_0000) ya[i] = 32'h8000_0000;
            else ya[i] = acc[i][31:0];
`else
            ya[i] = acc[i][31:0];
`endif
        end
    endfunction

    task automatic load(input bit sel);
        for (int i = 0; i < 4; i++) begin
            x1[i*32 +: 32] = xa[i];
            x2[i*32 +: 32] = xa[i];
            w1[i*32 +: 32] = wa[i];
        end
        for (int i = 0; i < 9; i++) w2[i*32 +: 32] = wa[i];
        if (sel) b2 = ba; else b1 = ba;
    endtask

    task automatic randomize_arrays(input bit wide);
        for (int i = 0; i < 4; i++) xa[i] = wide ? $urandom : 32'($signed($urandom_range(200)) - 100);
        for (int i = 0; i < 9; i++) wa[i] = wide ? $urandom : 32'($signed($urandom_range(200)) - 100);
        ba = wide ? $urandom : 32'($signed($urandom_range(2000)) - 1000);
    endtask

    // One run: start on edge 0, then observe L+8 further edges (bounded).
    task automatic run(input bit sel, input int pulse_at, input bit pulse_done, input int rst_at,
                       input bit scramble, output int done_edge, output int busy_cycles,
                       output int done_pulses);
        int lat;
        lat = sel ? 44 : 96;
        done_edge = -1;
        done_pulses = 0;
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        busy_cycles = (sel ? busy2 : busy1) ? 1 : 0;
        for (int e = 1; e <= lat + 8; e++) begin
            if (e == pulse_at || (pulse_done && e == lat + 1)) begin
                if (sel) start2 = 1'b1; else start1 = 1'b1;
            end
            if (scramble && e == 5) begin
                x1 = {$urandom, $urandom, $urandom, $urandom};
                x2 = x1;
                w1 = {$urandom, $urandom, $urandom, $urandom};
                w2 = {9{$urandom}};
                b1 = $urandom;
                b2 = $urandom;
            end
            if (e == rst_at) begin
                #3 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start2 = 1'b0;
            if (sel ? busy2 : busy1) busy_cycles++;
            if (sel ? done2 : done1) begin
                done_pulses++;
                if (done_edge < 0) done_edge = e;
            end
        end
    endtask

    task automatic check_outputs(input bit sel, input string tag);
        int n;
        n = sel ? 4 : 16;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_out%0d", tag, i), sel ? out2[i*32 +: 32] : out1[i*32 +: 32], ya[i]);
    endtask

    initial begin
        int de, bc, dp;
        x1 = '0; w1 = '0; b1 = '0; x2 = '0; w2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_out1_zero", |out1, 0);
        check("rst_busy2", busy2, 0);
        check("rst_out2_zero", |out2, 0);

        // Test 1: identity-diagonal kernel, stride-2 upsample
        xa = '{1, 2, 3, 4};
        wa = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        ba = 0;
        load(0);
        model(2, 2, 0);
        run(0, 0, 0, 0, 0, de, bc, dp);
        check("t1_done_edge", de, 97);
        check("t1_done_pulses", dp, 1);
        check_outputs(0, "t1");
        check("t1_out0_const", out1[31:0], 1);
        check("t1_out5_const", out1[5*32 +: 32], 1);
        check("t1_out15_const", out1[15*32 +: 32], 4);

        // Test 2: constant data with bias
        xa = '{2, 2, 2, 2};
        wa = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        ba = 5;
        load(0);
        model(2, 2, 0);
        run(0, 0, 0, 0, 0, de, bc, dp);
        check("t2_busy_cycles", bc, 96);
        check("t2_done_pulses", dp, 1);
        check("t2_done_edge", de, 97);
        check_outputs(0, "t2");

        // Test 3: start pulses while busy and in DONE are ignored
        xa = '{1, 2, 3, 4};
        wa = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        ba = 0;
        load(0);
        model(2, 2, 0);
        run(0, 30, 1, 0, 0, de, bc, dp);
        check("t3_done_edge", de, 97);
        check("t3_done_pulses", dp, 1);
        check("t3_busy_after", busy1, 0);
        check_outputs(0, "t3");

        // Test 4: reset mid-operation aborts, then a fresh start completes
        run(0, 0, 0, 40, 0, de, bc, dp);
        check("t4_done_pulses", dp, 0);
        check("t4_busy", busy1, 0);
        check("t4_out_zero", |out1, 0);
        run(0, 0, 0, 0, 0, de, bc, dp);
        check("t4b_done_edge", de, 97);
        check_outputs(0, "t4b");

        // Test 5: overflow boundary
        xa = '{32'h7FFF_FFFF, 0, 0, 0};
        wa = '{2, 0, 0, 0, 0, 0, 0, 0, 0};
        ba = 0;
        load(0);
        model(2, 2, 0);
        run(0, 0, 0, 0, 0, de, bc, dp);
`ifdef CONVT_SATURATE_EN
        check("t5_out0_const", out1[31:0], 32'h7FFF_FFFF);
`else
        check("t5_out0_const", out1[31:0], 32'hFFFF_FFFE);
`endif
        check_outputs(0, "t5");

        // Random data with bus changes after start (must be ignored)
        for (int r = 0; r < 4; r++) begin
            randomize_arrays(r >= 2);
            load(0);
            model(2, 2, 0);
            run(0, 0, 0, 0, 1, de, bc, dp);
            check($sformatf("rnd%0d_done_edge", r), de, 97);
            check_outputs(0, $sformatf("rnd%0d", r));
        end

        // Test 6: K=3, S=1, P=1 instance
        xa = '{1, 2, 3, 4};
        wa = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        ba = 0;
        load(1);
        model(3, 1, 1);
        run(1, 0, 0, 0, 0, de, bc, dp);
        check("t6_done_edge", de, 45);
        check("t6_busy_cycles", bc, 44);
        for (int i = 0; i < 4; i++) check($sformatf("t6_const%0d", i), out2[i*32 +: 32], 10);
        check_outputs(1, "t6");

        for (int r = 0; r < 2; r++) begin
            randomize_arrays(r == 1);
            load(1);
            model(3, 1, 1);
            run(1, 0, 0, 0, 1, de, bc, dp);
            check($sformatf("rndk3_%0d_done_edge", r), de, 45);
            check_outputs(1, $sformatf("rndk3_%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
